// File: rtl/random_matrix_fill.sv
// Fills a rows x cols matrix in memory with xorshift32 pseudo-random elements,
// one write per accepted handshake, starting at base_addr and wrapping the address space.
module random_matrix_fill #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_DIM    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           seed,
    input  logic [5:0]            rows,
    input  logic [5:0]            cols,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] value_mask,
    output logic                  wr_en,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // A zero seed would lock xorshift at zero forever, so it is replaced.
    localparam logic [31:0] ZERO_SEED_SUB = 32'h2545F491;
    localparam logic [6:0]  MAX_DIM_V     = 7'(MAX_DIM);

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        RUN,
        DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [31:0]             seed_q;
    logic [31:0]             prng_q;
    logic [31:0]             prng_next;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [DATA_WIDTH-1:0]   mask_q;
    logic [11:0]             index_q;
    logic [11:0]             total_q;
    logic [11:0]             job_total;
    logic                    error_q;
    logic                    dims_ok;
    logic                    take_job;
    logic                    accept;
    logic                    last;

    function automatic logic [31:0] xorshift32(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    assign dims_ok   = (rows != 6'd0) && ({1'b0, rows} <= MAX_DIM_V) &&
                       (cols != 6'd0) && ({1'b0, cols} <= MAX_DIM_V);
    assign job_total = {6'd0, rows} * {6'd0, cols};
    assign take_job  = (state_q == IDLE) && start && dims_ok;
    assign prng_next = xorshift32(prng_q);
    assign accept    = (state_q == RUN) && wr_ready;
    assign last      = (index_q == total_q - 12'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort takes priority over completion, so an aborted job never reports done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_job) begin
                    state_d = SEED;
                end
            end
            SEED: begin
                state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seed_q  <= '0;
            prng_q  <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            index_q <= '0;
            total_q <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= (state_q == IDLE) && start && !dims_ok;
            if (take_job) begin
                seed_q  <= seed;
                base_q  <= base_addr;
                mask_q  <= value_mask;
                total_q <= job_total;
            end
            if (state_q == SEED) begin
                prng_q  <= (seed_q == 32'd0) ? ZERO_SEED_SUB : seed_q;
                index_q <= '0;
            end
            if (accept) begin
                prng_q  <= prng_next;
                index_q <= index_q + 12'd1;
            end
        end
    end

    // Write outputs are pure decodes of held state, so they stay put while wr_ready is low.
    always_comb begin
        wr_en   = (state_q == RUN);
        wr_data = '0;
        wr_addr = '0;
        if (wr_en) begin
            wr_data = prng_next[DATA_WIDTH-1:0] & mask_q;
            wr_addr = base_q + ADDR_WIDTH'(index_q);
        end
        busy  = (state_q == SEED) || (state_q == RUN);
        done  = (state_q == DONE);
        error = error_q;
    end

endmodule

// File: tb/tb_random_matrix_fill.sv
// Self-checking bench for random_matrix_fill: directed and randomized fill jobs
// compared against a queue-based reference of the expected write sequence.
module tb_random_matrix_fill;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] seed;
    logic [5:0]  rows;
    logic [5:0]  cols;
    logic [9:0]  base_addr;
    logic [15:0] value_mask;
    logic        wr_en;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks;
    int n_fails;
    int ready_mode;
    int pat_pos;
    logic [15:0] exp_data[$];
    logic [9:0]  exp_addr[$];
    logic [15:0] obs_data[$];
    logic [9:0]  obs_addr[$];

    random_matrix_fill #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(10),
        .MAX_DIM(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .seed(seed),
        .rows(rows),
        .cols(cols),
        .base_addr(base_addr),
        .value_mask(value_mask),
        .wr_en(wr_en),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] xs32(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected write list: the i-th element is the i-th xorshift output from the seed.
    task automatic build_model(input logic [31:0] s0, input int r, input int c,
                               input logic [9:0] b, input logic [15:0] m);
        logic [31:0] s;
        exp_data.delete();
        exp_addr.delete();
        s = (s0 == 32'd0) ? 32'h2545F491 : s0;
        for (int i = 0; i < r * c; i++) begin
            s = xs32(s);
            exp_data.push_back(s[15:0] & m);
            exp_addr.push_back(10'((int'(b) + i) % 1024));
        end
    endtask

    function automatic logic pick_ready();
        logic [4:0] pattern;
        logic r;
        pattern = 5'b10010;
        case (ready_mode)
            0: r = 1'b1;
            1: begin
                r = pattern[pat_pos % 5];
                pat_pos++;
            end
            default: r = 1'($urandom_range(0, 1));
        endcase
        return r;
    endfunction

    task automatic apply_stimulus(input logic [31:0] s0, input int r, input int c,
                                  input logic [9:0] b, input logic [15:0] m,
                                  input int abort_after, input bit poke_start);
        int accepted;
        int cyc;
        int total;
        int budget;
        logic rdy;
        build_model(s0, r, c, b, m);
        obs_data.delete();
        obs_addr.delete();
        total  = r * c;
        budget = total * 20 + 50;
        pat_pos = 0;
        @(negedge clk);
        seed = s0; rows = 6'(r); cols = 6'(c); base_addr = b; value_mask = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("seed_busy", 32'(busy), 32'd1);
        check("seed_wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        accepted = 0;
        cyc = 0;
        while (accepted < total && !(abort_after >= 0 && accepted == abort_after) && cyc < budget) begin
            check("run_wr_en", 32'(wr_en), 32'd1);
            check("run_busy", 32'(busy), 32'd1);
            check("run_error", 32'(error), 32'd0);
            check("run_addr", 32'(wr_addr), 32'(exp_addr[accepted]));
            check("run_data", 32'(wr_data), 32'(exp_data[accepted]));
            rdy = pick_ready();
            wr_ready = rdy;
            start = poke_start && (cyc == 1);
            rows = poke_start ? 6'd0 : rows;
            if (rdy) begin
                obs_data.push_back(wr_data);
                obs_addr.push_back(wr_addr);
                accepted++;
            end
            @(negedge clk);
            cyc++;
        end
        wr_ready = 1'b0;
        start = 1'b0;
        if (cyc >= budget) begin
            check("run_timeout", 32'(cyc), 32'(budget - 1));
        end else if (abort_after >= 0 && accepted == abort_after) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_wr_en", 32'(wr_en), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            @(negedge clk);
            check("abort_done_late", 32'(done), 32'd0);
        end else begin
            check("done_pulse", 32'(done), 32'd1);
            check("done_busy", 32'(busy), 32'd0);
            check("done_wr_en", 32'(wr_en), 32'd0);
            @(negedge clk);
            check("done_clear", 32'(done), 32'd0);
            check("idle_wr_en", 32'(wr_en), 32'd0);
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic reject_job(input logic [5:0] r, input logic [5:0] c);
        @(negedge clk);
        rows = r; cols = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(error), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        check("err_clear", 32'(error), 32'd0);
        check("err_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fails = 0; ready_mode = 0; pat_pos = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wr_ready = 1'b0;
        seed = '0; rows = '0; cols = '0; base_addr = '0; value_mask = '0;
        repeat (3) @(negedge clk);
        check_output("reset");
        rst_n = 1'b1;

        // Known-answer job from seed 1.
        ready_mode = 0;
        apply_stimulus(32'd1, 1, 2, 10'h010, 16'hFFFF, -1, 1'b0);
        check("kat_data0", 32'(obs_data.size() > 0 ? obs_data[0] : 16'h0), 32'h2021);
        check("kat_data1", 32'(obs_data.size() > 1 ? obs_data[1] : 16'h0), 32'h0601);
        check("kat_addr1", 32'(obs_addr.size() > 1 ? obs_addr[1] : 10'h0), 32'h011);

        ready_mode = 1;
        apply_stimulus(32'd1, 1, 2, 10'h010, 16'hFFFF, -1, 1'b0);

        reject_job(6'd0, 6'd4);
        reject_job(6'd5, 6'd33);
        reject_job(6'd63, 6'd1);

        ready_mode = 0;
        apply_stimulus(32'd0, 1, 1, 10'h000, 16'h00FF, -1, 1'b0);
        apply_stimulus(32'h1234_5678, 1, 3, 10'h3FF, 16'hFFFF, -1, 1'b0);
        check("wrap_addr2", 32'(obs_addr.size() > 2 ? obs_addr[2] : 10'h3FF), 32'h001);

        apply_stimulus(32'hCAFE_0001, 4, 4, 10'h100, 16'hFFFF, 3, 1'b0);
        ready_mode = 2;
        apply_stimulus(32'hBEEF_0002, 4, 4, 10'h200, 16'h0F0F, -1, 1'b1);
        apply_stimulus(32'd7, 32, 1, 10'h3F0, 16'hFFFF, -1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            apply_stimulus($urandom, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                           10'($urandom), 16'($urandom), -1, 1'b0);
        end

        // Reset in the middle of a running job.
        ready_mode = 0;
        @(negedge clk);
        seed = 32'h55; rows = 6'd4; cols = 6'd4; base_addr = 10'h020; value_mask = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_wr_en", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midreset");
        rst_n = 1'b1;
        wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_done", 32'(done), 32'd0);

        apply_stimulus(32'h0BAD_F00D, 2, 3, 10'h050, 16'hFFFF, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
